pattern_checker: RTL and testbench
==================================

# pattern_checker

Synthesizable downstream consumer of the stimulus pattern generator's output. It samples the `stim_pattern` bus on a valid strobe, locks onto the first sample and checks that every later sample is exactly the previous one plus one (mod 2^STIM_SIZE). It counts full-range wraps and mismatches, and reports done/pass once the expected number of sweeps has been observed. It sits between the pattern generator and the result/log logic of the stimulus bench.

## Interface
- STIM_SIZE, 8, width of the incoming pattern
- CYCLES, 8, number of full sweeps (wraps through all-ones) expected before done
- ERR_W, 16, width of the saturating error counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset (one clock; sampled on rising edge of clk only)
- enable  input  1  run request, same meaning as the generator's enable
- stim_valid  input  1  sample strobe; stim_pattern is consumed only when high
- stim_pattern  input  STIM_SIZE  pattern under check
- done  output  1  sweep count reached; held until enable drops
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  ERR_W  mismatches seen, saturating
- wrap_count  output  $clog2(CYCLES+1)  all-ones samples seen in CHECK
- busy  output  1  high in SYNC or CHECK

## Operation
- States: IDLE, SYNC, CHECK, DONE.
- Reset: state=IDLE. done, pass, err_count, wrap_count, busy and the internal expected register are all 0.
- IDLE:
  - enable=1 → SYNC.
  - err_count, wrap_count and expected are cleared on this transition.
- SYNC:
  - First stim_valid sample: expected ← sample+1 (wrapping), then → CHECK.
  - This sample is never a mismatch.
  - If the sample is all-ones, wrap_count increments.
- CHECK, on each stim_valid:
  - Sample ≠ expected: err_count increments (saturates at 2^ERR_W−1) and expected ← sample+1. This resyncs, so one corrupted value costs exactly two errors.
  - Sample == expected: expected ← expected+1.
  - Sample == all-ones (whether it matched or not): wrap_count increments.
  - If the increment makes wrap_count reach CYCLES → DONE.
- DONE:
  - done=1 and pass=(err_count==0).
  - Samples are ignored and counters are frozen.
  - enable=0 → IDLE, and done/pass clear.
- enable=0 while in SYNC or CHECK → IDLE. Counters keep their values for inspection until the next IDLE→SYNC.
- stim_valid=0: no state, counter or expected change.
- Arithmetic on expected is STIM_SIZE-bit modular, so 2^STIM_SIZE−1 → 0 is a legal increment.

## Timing
- All outputs are registered. Counter and state effects of a sample taken on edge N are visible after edge N.
- done and pass assert on the edge that accepts the CYCLES-th all-ones sample.
- busy follows state with no extra delay.
- Back-to-back stim_valid on every cycle is supported. There is no backpressure and no ready signal.
- rst_n low overrides everything, including mid-CHECK: next state is IDLE with all outputs 0.
- If enable falls on the same edge as a valid sample in CHECK, the abort wins and the sample is discarded.

## Configuration
- PATTERN_CHK_SIG_EN defined:
  - Adds output `signature [STIM_SIZE-1:0]`.
  - Update rule on every sample accepted in SYNC or CHECK: sig ← {sig[STIM_SIZE-2:0], sig[STIM_SIZE-1]} ^ stim_pattern.
  - Cleared on reset and on IDLE→SYNC; frozen in DONE.
- Not defined: no signature port and no signature logic.

## Structure
- Package pattern_pkg holds:
  - the state enum type chk_state_t (IDLE, SYNC, CHECK, DONE);
  - a function returning the all-ones constant for a given width.
- The pattern generator shares the package.
- Sub-module pattern_misr contains the signature register and is instantiated only under PATTERN_CHK_SIG_EN.

## Test plan
All scenarios use STIM_SIZE=8 and CYCLES=2 unless stated.
- Reset: hold rst_n=0 for 3 cycles with enable=1 → state IDLE; done, pass, err_count, wrap_count and busy all 0.
- Clean run: enable=1, then valid samples 0x00..0xFF, 0x00..0xFF → done=1 on the edge after the second 0xFF, pass=1, err_count=0, wrap_count=2.
- Single corruption: same stream with 0x10 of the first sweep replaced by 0x55 → err_count=2, pass=0, done still asserts after the second 0xFF.
- Gaps and abort:
  - stim_valid low for 5 cycles mid-sweep → no counter change.
  - enable dropped in CHECK → IDLE on the next edge, done=0, counters retained.
  - re-enable → counters read 0.
- Saturation: ERR_W=2 with 5 isolated corrupted samples → err_count=3.
- PATTERN_CHK_SIG_EN: samples 0x01, 0x02 after sync → signature=0x01 after the first sample, then 0x02^0x02=0x00 after the second.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared types and helpers for the stimulus pattern generator and checker.
//   chk_state_t : checker FSM states (IDLE, SYNC, CHECK, DONE)
//   all_ones(w) : constant with the low w bits set, to be truncated to width w by the caller
package pattern_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} chk_state_t;
  function automatic logic [63:0] all_ones(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/pattern_misr.sv
// pattern_misr: rotate-and-xor signature over accepted pattern samples.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : clear the signature (start of a new run)
//   en_i       : fold data_i into the signature this cycle
//   data_i     : sample being folded in
//   sig_o      : current signature
module pattern_misr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);
  logic [W-1:0] sig_q, sig_d;
  always_comb sig_d = clr_i ? '0 : en_i ? ({sig_q[W-2:0], sig_q[W-1]} ^ data_i) : sig_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end
  assign sig_o = sig_q;
endmodule

// File: rtl/pattern_checker.sv
// pattern_checker: locks onto an incrementing pattern stream and counts mismatches and wraps.
//   clk, rst_n   : clock, synchronous active-low reset
//   enable       : run request; dropping it aborts a run or releases DONE
//   stim_valid   : sample strobe for stim_pattern
//   stim_pattern : sample under check
//   done, pass   : sweep count reached / no mismatches seen (pass meaningful with done)
//   err_count    : saturating mismatch count
//   wrap_count   : all-ones samples seen in the current run
//   busy         : run in progress (SYNC or CHECK)
//   signature    : sample signature, present only when PATTERN_CHK_SIG_EN is defined
module pattern_checker
  import pattern_pkg::*;
#(
  parameter int STIM_SIZE = 8,
  parameter int CYCLES    = 8,
  parameter int ERR_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          stim_valid,
  input  logic [STIM_SIZE-1:0]          stim_pattern,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_W-1:0]              err_count,
  output logic [$clog2(CYCLES+1)-1:0]   wrap_count,
  output logic                          busy
`ifdef PATTERN_CHK_SIG_EN
  ,
  output logic [STIM_SIZE-1:0]          signature
`endif
);
  localparam int WW = $clog2(CYCLES + 1);
  localparam logic [STIM_SIZE-1:0] ONES    = STIM_SIZE'(all_ones(STIM_SIZE));
  localparam logic [ERR_W-1:0]     ERR_MAX = ERR_W'(all_ones(ERR_W));
  chk_state_t           state_q, state_d;
  logic [STIM_SIZE-1:0] exp_q, exp_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [WW-1:0]        wrap_q, wrap_d, wrap_inc;
  assign wrap_inc = wrap_q + WW'(stim_pattern == ONES);
  // Both the match and resync cases leave expected at sample+1, so one corrupted
  // value costs exactly two errors: itself and the following good sample.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = err_q;
    wrap_d  = wrap_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = SYNC;
        exp_d   = '0;
        err_d   = '0;
        wrap_d  = '0;
      end
      SYNC, CHECK: if (!enable) state_d = IDLE;
      else if (stim_valid) begin
        exp_d   = stim_pattern + 1'b1;
        err_d   = (state_q == CHECK && stim_pattern != exp_q && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
        wrap_d  = wrap_inc;
        state_d = (wrap_inc == WW'(CYCLES)) ? DONE : CHECK;
      end
      default: if (!enable) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      err_q   <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end
  assign busy       = (state_q == SYNC) || (state_q == CHECK);
  assign done       = state_q == DONE;
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign wrap_count = wrap_q;
`ifdef PATTERN_CHK_SIG_EN
  logic sig_clr, sig_take;
  assign sig_clr  = (state_q == IDLE) && enable;
  assign sig_take = busy && enable && stim_valid;
  pattern_misr #(.W(STIM_SIZE)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (sig_clr),
    .en_i   (sig_take),
    .data_i (stim_pattern),
    .sig_o  (signature)
  );
`endif
endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: scoreboard bench comparing pattern_checker against a stream-level reference model.
module tb_pattern_checker;
  localparam int CYC = 2;
  localparam int WW  = $clog2(CYC + 1);
  logic clk = 0, rst_n = 0, enable = 0, stim_valid = 0;
  logic [7:0] stim_pattern = 0;
  logic done, pass, busy, s_done, s_pass, s_busy;
  logic [15:0] err_count;
  logic [1:0] s_err;
  logic [WW-1:0] wrap_count, s_wrap;
`ifdef PATTERN_CHK_SIG_EN
  logic [7:0] signature, s_sig;
`endif
  pattern_checker #(.STIM_SIZE(8), .CYCLES(CYC), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stim_valid(stim_valid), .stim_pattern(stim_pattern),
    .done(done), .pass(pass), .err_count(err_count), .wrap_count(wrap_count), .busy(busy)
`ifdef PATTERN_CHK_SIG_EN
    , .signature(signature)
`endif
  );
  pattern_checker #(.STIM_SIZE(8), .CYCLES(CYC), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stim_valid(stim_valid), .stim_pattern(stim_pattern),
    .done(s_done), .pass(s_pass), .err_count(s_err), .wrap_count(s_wrap), .busy(s_busy)
`ifdef PATTERN_CHK_SIG_EN
    , .signature(s_sig)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       done;
    logic       pass;
    logic       busy;
    int         err;
    int         wrap;
    logic [7:0] sig;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit m_run, m_lock, m_fin;
  int m_err, m_wrap;
  logic [7:0] m_prev, m_sig;
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  // Reference: a sample is an error iff it is not the previous accepted sample + 1
  // within a run; a run finishes once CYC all-ones samples have been accepted.
  task automatic step(bit r, bit e, bit v, logic [7:0] d);
    exp_t x;
    #1;
    rst_n = r;
    enable = e;
    stim_valid = v;
    stim_pattern = d;
    @(posedge clk);
    if (!r) begin
      m_run = 0; m_lock = 0; m_fin = 0; m_err = 0; m_wrap = 0; m_sig = 0;
    end else if (m_fin) begin
      if (!e) m_fin = 0;
    end else if (!m_run) begin
      if (e) begin
        m_run = 1; m_lock = 0; m_err = 0; m_wrap = 0; m_sig = 0;
      end
    end else if (!e) begin
      m_run = 0;
    end else if (v) begin
      if (m_lock && d != 8'(m_prev + 8'd1)) m_err++;
      m_lock = 1;
      m_prev = d;
      m_sig = {m_sig[6:0], m_sig[7]} ^ d;
      if (d == 8'hFF) m_wrap++;
      if (m_wrap == CYC) begin
        m_run = 0;
        m_fin = 1;
      end
    end
    x.done = m_fin;
    x.pass = m_fin && m_err == 0;
    x.busy = m_run;
    x.err  = m_err;
    x.wrap = m_wrap;
    x.sig  = m_sig;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("done", 32'(done), 32'(x.done));
      chk("pass", 32'(pass), 32'(x.pass));
      chk("busy", 32'(busy), 32'(x.busy));
      chk("err_count", 32'(err_count), x.err);
      chk("wrap_count", 32'(wrap_count), x.wrap);
      chk("sat_err_count", 32'(s_err), (x.err > 3) ? 3 : x.err);
      chk("sat_done", 32'(s_done), 32'(x.done));
`ifdef PATTERN_CHK_SIG_EN
      chk("signature", 32'(signature), 32'(x.sig));
`endif
    end
  end
  initial begin
    logic [7:0] n;
    repeat (3) step(0, 1, 0, 8'h00);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_wrap", 32'(wrap_count), 0);
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 512; i++) step(1, 1, 1, 8'(i));
    #2;
    chk("clean_done", 32'(done), 1);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_err", 32'(err_count), 0);
    chk("clean_wrap", 32'(wrap_count), 2);
    step(1, 1, 1, 8'h00);
    step(1, 1, 1, 8'h37);
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 512; i++) step(1, 1, 1, (i == 16) ? 8'h55 : 8'(i));
    #2;
    chk("corrupt_err", 32'(err_count), 2);
    chk("corrupt_pass", 32'(pass), 0);
    chk("corrupt_done", 32'(done), 1);
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 64; i++) step(1, 1, 1, 8'(i));
    repeat (5) step(1, 1, 0, 8'hAA);
    #2;
    chk("gap_err", 32'(err_count), 0);
    chk("gap_wrap", 32'(wrap_count), 0);
    for (int i = 64; i < 301; i++) step(1, 1, 1, 8'(i));
    step(1, 0, 1, 8'hFF);
    #2;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_wrap", 32'(wrap_count), 1);
    chk("abort_err", 32'(err_count), 0);
    step(1, 1, 0, 8'h00);
    #2;
    chk("reen_wrap", 32'(wrap_count), 0);
    chk("reen_busy", 32'(busy), 1);
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 3) == 0) step(1, 1, 0, 8'($urandom));
      step(1, 1, 1, (i % 40 == 20 && i < 200) ? 8'(i) ^ 8'h80 : 8'(i));
    end
    #2;
    chk("sat_err_full", 32'(err_count), 10);
    chk("sat_err_2bit", 32'(s_err), 3);
    step(1, 0, 0, 8'h00);
    for (int run = 0; run < 3; run++) begin
      n = 8'($urandom);
      step(1, 1, 0, 8'h00);
      for (int c = 0; c < 700; c++) begin
        if (run == 1 && c == 350) step(0, 1, 0, 8'h00);
        else if ($urandom_range(0, 3) == 0) step(1, 1, 0, 8'($urandom));
        else begin
          step(1, 1, 1, ($urandom_range(0, 31) == 0) ? 8'($urandom) : n);
          n = n + 8'd1;
        end
      end
      step(1, 0, 0, 8'h00);
    end
`ifdef PATTERN_CHK_SIG_EN
    step(1, 1, 0, 8'h00);
    step(1, 1, 1, 8'h01);
    #2;
    chk("sig_first", 32'(signature), 32'h01);
    step(1, 1, 1, 8'h02);
    #2;
    chk("sig_second", 32'(signature), 32'h00);
    step(1, 0, 0, 8'h00);
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
